// File: rtl/ir_fetch_align_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the fetch align buffer.
// Names carry the buffer's point of view: _i flows into it, _o flows out of it.
interface ir_fetch_align_buffer_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_compressed_o;
  logic        out_illegal_o;
  logic        out_fault_o;

  modport master (
    output flush_i, flush_pc_i, in_valid_i, in_data_i, in_err_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_compressed_o,
           out_illegal_o, out_fault_o
  );

  modport slave (
    input  flush_i, flush_pc_i, in_valid_i, in_data_i, in_err_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_compressed_o,
           out_illegal_o, out_fault_o
  );
endinterface

// File: rtl/ir_fetch_align_buffer.sv
// Halfword queue that realigns fetched words into one RV32(C) instruction per cycle.
// 1-cycle fill; in_ready drops once fewer than two free slots remain, head holds under stall.
module IR_Decompression (
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);
  logic [15:0] c;
  logic [4:0]  rd_p, rs1_p;
  logic [2:0]  f3;

  assign c     = instr_i;
  assign rd_p  = {2'b01, c[4:2]};
  assign rs1_p = {2'b01, c[9:7]};

  always_comb begin
    instr_o   = 32'h0;
    illegal_o = 1'b0;
    f3        = 3'b000;
    case (c[1:0])
      2'b00: case (c[15:13])
        3'b000: begin
          instr_o   = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rd_p, 7'h13};
          illegal_o = (c[12:5] == 8'h0);
        end
        3'b010:  instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1_p, 3'b010, rd_p, 7'h03};
        3'b110:  instr_o = {5'b0, c[5], c[12], rd_p, rs1_p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
        default: illegal_o = 1'b1;
      endcase
      2'b01: case (c[15:13])
        3'b000: instr_o = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], 7'h13};
        3'b001, 3'b101:
          instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}},
                     (c[15] ? 5'd0 : 5'd1), 7'h6f};
        3'b010: instr_o = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], 7'h13};
        3'b011: begin
          if (c[11:7] == 5'd2)
            instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
          else
            instr_o = {{15{c[12]}}, c[6:2], c[11:7], 7'h37};
          illegal_o = ({c[12], c[6:2]} == 6'h0);
        end
        3'b100: case (c[11:10])
          2'b00: begin
            instr_o   = {7'b0, c[6:2], rs1_p, 3'b101, rs1_p, 7'h13};
            illegal_o = c[12];
          end
          2'b01: begin
            instr_o   = {7'b0100000, c[6:2], rs1_p, 3'b101, rs1_p, 7'h13};
            illegal_o = c[12];
          end
          2'b10: instr_o = {{7{c[12]}}, c[6:2], rs1_p, 3'b111, rs1_p, 7'h13};
          default: begin
            case (c[6:5])
              2'b00:   f3 = 3'b000;
              2'b01:   f3 = 3'b100;
              2'b10:   f3 = 3'b110;
              default: f3 = 3'b111;
            endcase
            instr_o   = {((c[6:5] == 2'b00) ? 7'b0100000 : 7'b0), rd_p, rs1_p, f3, rs1_p, 7'h33};
            illegal_o = c[12];
          end
        endcase
        default:
          instr_o = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1_p, {2'b00, c[13]}, c[11:10], c[4:3],
                     c[12], 7'h63};
      endcase
      2'b10: case (c[15:13])
        3'b000: begin
          instr_o   = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], 7'h13};
          illegal_o = c[12];
        end
        3'b010: begin
          instr_o   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], 7'h03};
          illegal_o = (c[11:7] == 5'd0);
        end
        3'b100: begin
          if (c[6:2] != 5'd0)
            instr_o = {7'b0, c[6:2], (c[12] ? c[11:7] : 5'd0), 3'b000, c[11:7], 7'h33};
          else if (!c[12]) begin
            instr_o   = {12'b0, c[11:7], 3'b000, 5'd0, 7'h67};
            illegal_o = (c[11:7] == 5'd0);
          end else if (c[11:7] == 5'd0)
            instr_o = 32'h0010_0073;
          else
            instr_o = {12'b0, c[11:7], 3'b000, 5'd1, 7'h67};
        end
        3'b110:  instr_o = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
        default: illegal_o = 1'b1;
      endcase
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

module ir_fetch_align_buffer #(
  parameter int          BUF_HALFWORDS = 6,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          ENABLE_C      = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  ir_fetch_align_buffer_if.slave  bus
);
  localparam int PW = $clog2(BUF_HALFWORDS);
  localparam int CW = $clog2(BUF_HALFWORDS + 1);
  localparam int SW = CW + 1;

  logic [15:0]   dat_q [BUF_HALFWORDS];
  logic          err_q [BUF_HALFWORDS];
  logic [CW-1:0] cnt_q, cnt_d, push_len, pop_len;
  logic [PW-1:0] rd_q, rd_d, rd_nx, wr_ptr, wr_nx;
  logic [31:1]   pc_q, pc_d;
  logic          skip_q, skip_d;
  logic [15:0]   h0, h1;
  logic          is_comp, push, pop, fault;
  logic [31:0]   exp_instr;
  logic          exp_illegal;
  logic          unused_flush_lsb;

  // Circular storage: non power-of-two capacities need an explicit wrap.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(p) + SW'(n);
    if (s >= SW'(BUF_HALFWORDS)) s = s - SW'(BUF_HALFWORDS);
    return s[PW-1:0];
  endfunction

  assign unused_flush_lsb = bus.flush_pc_i[0];
  assign rd_nx    = ptr_add(rd_q, CW'(1));
  assign wr_ptr   = ptr_add(rd_q, cnt_q);
  assign wr_nx    = ptr_add(wr_ptr, CW'(1));
  assign h0       = dat_q[rd_q];
  assign h1       = dat_q[rd_nx];
  assign is_comp  = (h0[1:0] != 2'b11);
  assign pop_len  = is_comp ? CW'(1) : CW'(2);
  assign push_len = skip_q ? CW'(1) : CW'(2);

  assign bus.in_ready_o  = (cnt_q <= CW'(BUF_HALFWORDS - 2));
  assign bus.out_valid_o = is_comp ? (cnt_q != '0) : (cnt_q >= CW'(2));
  assign push = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
  assign pop  = bus.out_valid_o && bus.out_ready_i && !bus.flush_i;

  always_comb begin
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    pc_d   = pc_q;
    skip_d = skip_q;
    if (bus.flush_i) begin
      cnt_d  = '0;
      pc_d   = bus.flush_pc_i[31:1];
      skip_d = bus.flush_pc_i[1];
    end else begin
      if (push) skip_d = 1'b0;
      if (pop) begin
        rd_d = ptr_add(rd_q, pop_len);
        pc_d = pc_q + 31'(pop_len);
      end
      cnt_d = cnt_q + (push ? push_len : '0) - (pop ? pop_len : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      pc_q   <= RESET_PC[31:1];
      skip_q <= RESET_PC[1];
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip_q) begin
        dat_q[wr_ptr] <= bus.in_data_i[31:16];
        err_q[wr_ptr] <= bus.in_err_i;
      end else begin
        dat_q[wr_ptr] <= bus.in_data_i[15:0];
        err_q[wr_ptr] <= bus.in_err_i;
        dat_q[wr_nx]  <= bus.in_data_i[31:16];
        err_q[wr_nx]  <= bus.in_err_i;
      end
    end
  end

  IR_Decompression u_rvc (.instr_i(h0), .instr_o(exp_instr), .illegal_o(exp_illegal));

  assign fault                = err_q[rd_q] | (!is_comp & err_q[rd_nx]);
  assign bus.out_fault_o      = fault;
  assign bus.out_pc_o         = {pc_q, 1'b0};
  assign bus.out_compressed_o = is_comp;

  always_comb begin
    bus.out_instr_o   = {h1, h0};
    bus.out_illegal_o = 1'b0;
    if (is_comp) begin
      if (ENABLE_C) begin
        bus.out_instr_o   = exp_instr;
        bus.out_illegal_o = exp_illegal;
      end else begin
        bus.out_instr_o   = {16'h0, h0};
        bus.out_illegal_o = 1'b1;
      end
    end
    if (fault) bus.out_illegal_o = 1'b0;
  end
endmodule

// File: tb/tb_ir_fetch_align_buffer.sv
// Randomised scoreboard bench: instruction streams laid out as halfwords at a PC, expected
// results queued at issue and popped by an independent monitor with random backpressure.
module tb_ir_fetch_align_buffer;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_fetch_align_buffer_if bus ();
  ir_fetch_align_buffer_if bnc ();

  ir_fetch_align_buffer #(.BUF_HALFWORDS(N)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ir_fetch_align_buffer #(.BUF_HALFWORDS(N), .ENABLE_C(1'b0)) u_nc (.clk(clk), .rst_n(rst_n), .bus(bnc));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
    logic        flt;
    bit          chk_instr;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seg_ins[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int bp_pct = 0;
  bit   mon_en = 1'b0;
  logic mon_rdy = 1'b0;
  logic drv_rdy = 1'b0;

  assign bus.out_ready_i = mon_en ? mon_rdy : drv_rdy;

  // Hand-assembled RV32C encodings and their 32-bit equivalents.
  logic [15:0] ct_hw [15] = '{16'h4501, 16'h4505, 16'h0000, 16'h0085, 16'h852E, 16'h952E, 16'h4080,
                              16'hA001, 16'h9002, 16'h8082, 16'h050E, 16'h4002, 16'h6141, 16'hC001, 16'h0001};
  logic [31:0] ct_ex [15] = '{32'h00000513, 32'h00100513, 32'h0, 32'h00108093, 32'h00B00533, 32'h00B50533,
                              32'h0004A403, 32'h0000006F, 32'h00100073, 32'h00008067, 32'h00351513, 32'h0,
                              32'h01010113, 32'h00040063, 32'h00000013};
  bit          ct_il [15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic int cidx(input logic [15:0] h);
    for (int i = 0; i < 15; i++) if (ct_hw[i] == h) return i;
    return 0;
  endfunction

  task automatic run_seg(input logic [31:0] pc, input bit do_flush, input int n_rand,
                         input int err_pct, input int gap_pct);
    logic [15:0] hw[$];
    logic        werr[$];
    logic [31:0] words[$];
    logic [31:0] r, p;
    exp_t        e;
    int          k, tot, idx, cyc, ci;
    bit          v, rdy;
    for (int i = 0; i < n_rand; i++) begin
      if ($urandom_range(0, 1) == 0) seg_ins.push_back({16'h0, ct_hw[$urandom_range(0, 14)]});
      else begin
        r = $urandom;
        r[1:0] = 2'b11;
        seg_ins.push_back(r);
      end
    end
    tot = int'(pc[1]);
    foreach (seg_ins[i]) tot += (seg_ins[i][1:0] != 2'b11) ? 1 : 2;
    if (tot % 2 != 0) seg_ins.push_back(32'h0001);
    if (pc[1]) hw.push_back(16'($urandom));
    foreach (seg_ins[i]) begin
      hw.push_back(seg_ins[i][15:0]);
      if (seg_ins[i][1:0] == 2'b11) hw.push_back(seg_ins[i][31:16]);
    end
    for (int w = 0; w < hw.size() / 2; w++) begin
      words.push_back({hw[2*w+1], hw[2*w]});
      werr.push_back($urandom_range(0, 99) < err_pct);
    end
    k = int'(pc[1]);
    p = pc;
    foreach (seg_ins[i]) begin
      e.comp = (seg_ins[i][1:0] != 2'b11);
      e.len  = e.comp ? 1 : 2;
      e.flt  = werr[k/2] | (!e.comp && werr[(k+1)/2]);
      e.pc   = p;
      if (e.comp) begin
        ci = cidx(seg_ins[i][15:0]);
        e.instr = ct_ex[ci];
        e.chk_instr = !ct_il[ci];
        e.ill = ct_il[ci] && !e.flt;
      end else begin
        e.instr = seg_ins[i];
        e.chk_instr = 1'b1;
        e.ill = 1'b0;
      end
      exp_q.push_back(e);
      k += e.len;
      p += 32'(2 * e.len);
    end
    seg_ins.delete();
    if (do_flush) begin
      @(negedge clk);
      bus.flush_i = 1'b1;
      bus.flush_pc_i = pc | 32'($urandom_range(0, 1));
      @(negedge clk);
      bus.flush_i = 1'b0;
    end
    idx = 0;
    cyc = 0;
    while (idx < words.size() && cyc < 3000) begin
      @(negedge clk);
      v = ($urandom_range(0, 99) >= gap_pct);
      bus.in_valid_i = v;
      bus.in_data_i  = words[idx];
      bus.in_err_i   = werr[idx];
      rdy = bus.in_ready_o;
      @(posedge clk);
      if (v && rdy) begin
        pushed += (idx == 0 && pc[1]) ? 1 : 2;
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    if (idx < words.size()) chk("drive_timeout", 32'(idx), 32'(words.size()));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: random ready, scoreboard pop, occupancy-derived in_ready, hold stability.
  initial begin
    exp_t e;
    bit take, hold;
    int plen;
    logic [31:0] s_instr, s_pc;
    logic s_comp, s_ill, s_flt;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("in_ready", 32'(bus.in_ready_o), 32'((pushed - popped) <= N - 2));
        if (hold) begin
          chk("stable_valid", 32'(bus.out_valid_o), 32'd1);
          chk("stable_instr", bus.out_instr_o, s_instr);
          chk("stable_pc", bus.out_pc_o, s_pc);
          chk("stable_flags", {29'h0, bus.out_compressed_o, bus.out_illegal_o, bus.out_fault_o},
              {29'h0, s_comp, s_ill, s_flt});
        end
        mon_rdy = ($urandom_range(0, 99) >= bp_pct);
        take = bus.out_valid_o && mon_rdy;
        plen = 0;
        if (take) begin
          if (exp_q.size() == 0) chk("unexpected_output", bus.out_pc_o, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            plen = e.len;
            chk("pc", bus.out_pc_o, e.pc);
            chk("compressed", 32'(bus.out_compressed_o), 32'(e.comp));
            chk("illegal", 32'(bus.out_illegal_o), 32'(e.ill));
            chk("fault", 32'(bus.out_fault_o), 32'(e.flt));
            if (e.chk_instr) chk("instr", bus.out_instr_o, e.instr);
          end
        end
        hold = bus.out_valid_o && !mon_rdy;
        s_instr = bus.out_instr_o;
        s_pc = bus.out_pc_o;
        s_comp = bus.out_compressed_o;
        s_ill = bus.out_illegal_o;
        s_flt = bus.out_fault_o;
        @(posedge clk);
        popped += plen;
      end else begin
        hold = 1'b0;
        mon_rdy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bus.flush_i = 1'b1;  bus.flush_pc_i = 32'h0000_0102;
    bus.in_valid_i = 1'b0; bus.in_data_i = 32'h0; bus.in_err_i = 1'b0;
    bnc.flush_i = 1'b0;  bnc.flush_pc_i = 32'h0;
    bnc.in_valid_i = 1'b0; bnc.in_data_i = 32'h0; bnc.in_err_i = 1'b0; bnc.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.flush_i = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_nc_out_valid", 32'(bnc.out_valid_o), 32'd0);
    chk("rst_nc_in_ready", 32'(bnc.in_ready_o), 32'd1);
    mon_en = 1'b1;

    seg_ins = '{32'h00A00093};               run_seg(32'h0, 1'b0, 0, 0, 0);
    seg_ins = '{32'h4501, 32'h4505};         run_seg(32'h0, 1'b1, 0, 0, 0);
    seg_ins = '{32'h4501, 32'h00A00093};     run_seg(32'h0, 1'b1, 0, 0, 70);
    seg_ins = '{32'h4505};                   run_seg(32'h0000_0102, 1'b1, 0, 0, 0);
    seg_ins = '{32'h00A00093, 32'h4501};     run_seg(32'h0000_0010, 1'b1, 0, 100, 0);
    seg_ins = '{32'h0000, 32'h4505};         run_seg(32'h0000_0040, 1'b1, 0, 0, 0);
    run_seg(32'hFFFF_FFFA, 1'b1, 6, 0, 0);
    bp_pct = 90;
    run_seg(32'h0000_1002, 1'b1, 20, 0, 0);
    for (int s = 0; s < 30; s++) begin
      bp_pct = $urandom_range(0, 60);
      run_seg($urandom & 32'hFFFF_FFFE, 1'b1, $urandom_range(1, 12), 10, $urandom_range(0, 50));
    end

    // Flush racing a push and a pop in the same cycle.
    @(posedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h0000_0200;
    @(negedge clk);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b1; bus.in_data_i = 32'h4505_4501;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("pre_flush_valid", 32'(bus.out_valid_o), 32'd1);
    chk("pre_flush_pc", bus.out_pc_o, 32'h0000_0200);
    bus.flush_i = 1'b1; bus.flush_pc_i = 32'h0000_0300;
    bus.in_valid_i = 1'b1; bus.in_data_i = 32'h0085_0085; drv_rdy = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; drv_rdy = 1'b0;
    chk("post_flush_valid", 32'(bus.out_valid_o), 32'd0);
    chk("post_flush_in_ready", 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i = 1'b1; bus.in_data_i = 32'h4505_4501;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("refill_pc", bus.out_pc_o, 32'h0000_0300);
    chk("refill_instr", bus.out_instr_o, 32'h0000_0513);

    // Expansion disabled: compressed halfwords surface as illegal.
    bnc.in_valid_i = 1'b1; bnc.in_data_i = 32'h0000_4501;
    @(negedge clk);
    bnc.in_valid_i = 1'b0;
    chk("nc_valid", 32'(bnc.out_valid_o), 32'd1);
    chk("nc_illegal", 32'(bnc.out_illegal_o), 32'd1);
    chk("nc_compressed", 32'(bnc.out_compressed_o), 32'd1);
    chk("nc_pc", bnc.out_pc_o, 32'h0);
    bnc.out_ready_i = 1'b1;
    @(negedge clk);
    bnc.out_ready_i = 1'b0;
    chk("nc_pc2", bnc.out_pc_o, 32'h2);
    chk("nc_illegal2", 32'(bnc.out_illegal_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
